// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter
// state encoding and the default bit period.
package uart_pkg;

  localparam int UART_CLK_PER_BIT_DEFAULT = 868;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; head is read
// combinationally, push is accepted when full only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem_q[rptr_q];
  assign count   = cnt_q;

  // Next pointers and occupancy
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop_ok)  rptr_d = rptr_q + 1'b1;
    if (push_ok && !pop_ok) cnt_d = cnt_q + 1'b1;
    if (!push_ok && pop_ok) cnt_d = cnt_q - 1'b1;
  end

  // Storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata;
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a byte FIFO, with
// sticky framing-error and overrun flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = UART_CLK_PER_BIT_DEFAULT,
  parameter int DEPTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rxd,
  output logic [7:0]                 rdata,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic                       clr_err,
  output logic                       overrun,
  output logic                       ferr
);

  localparam int BW = $clog2(CLK_PER_BIT);
  localparam logic [BW-1:0] HALF_M1 = BW'(CLK_PER_BIT/2 - 1);
  localparam logic [BW-1:0] FULL_M1 = BW'(CLK_PER_BIT - 1);

  logic          s1_q, s2_q, rxd_d_q;
  logic          rxd_s;
  logic [2:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          push;
  logic          ferr_set;
  logic          ovr_set;
  logic          full;
  logic          empty;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;

  assign rxd_s = s2_q;

  // Two-flop synchroniser plus edge-detect delay, idle high
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      rxd_d_q <= 1'b1;
    end else begin
      s1_q    <= rxd;
      s2_q    <= s1_q;
      rxd_d_q <= s2_q;
    end
  end

  // Receiver FSM: start detect, mid-bit sampling, stop check
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rxd_d_q && !rxd_s) begin
          state_d = ST_START;
          baud_d  = '0;
        end
      end
      ST_START: begin
        if (baud_q == HALF_M1) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = rxd_s ? ST_IDLE : ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_q == FULL_M1) begin
          baud_d  = '0;
          shift_d = {rxd_s, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_q == FULL_M1) begin
          baud_d = '0;
          if (rxd_s) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = ST_WAIT_HIGH;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_WAIT_HIGH: begin
        if (rxd_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM registers; shift register holds no meaningful reset value
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
    end
    shift_q <= shift_d;
  end

  // A full FIFO only drops the byte if nothing leaves this cycle
  assign ovr_set = push && full && !rready;
  assign ferr_d  = (ferr_q && !clr_err) || ferr_set;
  assign ovr_d   = (ovr_q && !clr_err) || ovr_set;

  // Sticky error flags, a new event beats a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      ferr_q <= ferr_d;
      ovr_q  <= ovr_d;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (shift_q),
    .pop   (rready),
    .rdata (rdata),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  assign rvalid  = !empty;
  assign overrun = ovr_q;
  assign ferr    = ferr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and random serial frames against a
// queue-based model of the receive FIFO.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] rdata;
  logic       rvalid;
  logic       rready;
  logic [2:0] count;
  logic       clr_err;
  logic       overrun;
  logic       ferr;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] q[$];
  logic       m_ovr;
  logic       m_ferr;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_PER_BIT (CPB),
    .DEPTH       (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rxd     (rxd),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .rready  (rready),
    .count   (count),
    .clr_err (clr_err),
    .overrun (overrun),
    .ferr    (ferr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic stop);
    #1 rxd = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rxd = b[i];
      repeat (CPB) @(posedge clk);
    end
    #1 rxd = stop;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic idle(input int n);
    #1 rxd = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  function automatic void m_push(input logic [7:0] b);
    if (q.size() < DEPTH) q.push_back(b);
    else m_ovr = 1'b1;
  endfunction

  task automatic check_state(input string tag);
    @(negedge clk);
    chk({tag, ".count"}, 32'(count), q.size());
    chk({tag, ".rvalid"}, 32'(rvalid), 32'(q.size() != 0));
    chk({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
    chk({tag, ".ferr"}, 32'(ferr), 32'(m_ferr));
    if (q.size() != 0)
      chk({tag, ".rdata"}, 32'(rdata), 32'(q[0]));
  endtask

  task automatic pop_check(input string tag);
    @(negedge clk);
    chk({tag, ".pv"}, 32'(rvalid), 1);
    chk({tag, ".pd"}, 32'(rdata), 32'(q[0]));
    rready = 1'b1;
    @(posedge clk);
    #1 rready = 1'b0;
    void'(q.pop_front());
  endtask

  task automatic clear_errs();
    @(posedge clk);
    #1 clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    rst     = 1'b1;
    rxd     = 1'b1;
    rready  = 1'b0;
    clr_err = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_state("reset");
    idle(4);

    // 1: single byte, rvalid rise timing
    fork
      send_frame(8'h55, 1'b1);
      begin
        @(negedge rxd);
        repeat (154) @(posedge clk);
        @(negedge clk);
        chk("t1.early", 32'(rvalid), 0);
        @(posedge clk);
        @(negedge clk);
        chk("t1.rise", 32'(rvalid), 1);
        chk("t1.data", 32'(rdata), 32'h55);
        chk("t1.cnt", 32'(count), 1);
      end
    join
    q.push_back(8'h55);
    pop_check("t1.pop");
    check_state("t1.empty");

    // 2: overrun on fifth back-to-back frame
    @(posedge clk);
    foreach (q[i]) ;
    for (int i = 0; i < 5; i++) begin
      b = (i == 4) ? 8'hA5 : 8'(i);
      send_frame(b, 1'b1);
      m_push(b);
    end
    check_state("t2.full");
    for (int i = 0; i < 4; i++) pop_check("t2.pop");
    clear_errs();
    check_state("t2.clr");

    // 3: framing error then good frame
    idle(4);
    send_frame(8'h3C, 1'b0);
    m_ferr = 1'b1;
    idle(8);
    check_state("t3.ferr");
    send_frame(8'h81, 1'b1);
    m_push(8'h81);
    check_state("t3.rx");
    pop_check("t3.pop");
    clear_errs();

    // 4: short glitch is ignored
    #1 rxd = 1'b0;
    repeat (4) @(posedge clk);
    idle(40);
    check_state("t4.glitch");
    send_frame(8'h6E, 1'b1);
    m_push(8'h6E);
    check_state("t4.after");
    pop_check("t4.pop");

    // 5: push and pop in the same cycle while full
    idle(4);
    for (int i = 0; i < 4; i++) begin
      send_frame(8'(8'h10 + i), 1'b1);
      m_push(8'(8'h10 + i));
    end
    check_state("t5.full");
    idle(2);
    fork
      send_frame(8'h14, 1'b1);
      begin
        @(negedge rxd);
        repeat (154) @(posedge clk);
        #1 rready = 1'b1;
        @(posedge clk);
        #1 rready = 1'b0;
      end
    join
    void'(q.pop_front());
    q.push_back(8'h14);
    check_state("t5.same");
    for (int i = 0; i < 4; i++) pop_check("t5.pop");

    // 6: reset mid-frame
    idle(4);
    send_frame(8'hE1, 1'b1);
    m_push(8'hE1);
    send_frame(8'h1E, 1'b1);
    m_push(8'h1E);
    check_state("t6.two");
    idle(2);
    fork
      send_frame(8'hF8, 1'b1);
      begin
        @(negedge rxd);
        repeat (CPB * 4 + 8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    q.delete();
    check_state("t6.rst");
    idle(4);
    send_frame(8'hC3, 1'b1);
    m_push(8'hC3);
    check_state("t6.rx");
    pop_check("t6.pop");

    // random frames with random pops and gaps
    idle(4);
    for (int i = 0; i < 14; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      m_push(b);
      check_state("rnd.rx");
      if (q.size() != 0 && $urandom_range(0, 2) == 0)
        pop_check("rnd.pop");
      idle($urandom_range(0, 3));
    end
    while (q.size() != 0) pop_check("rnd.drain");
    clear_errs();
    check_state("rnd.end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

UART receive stage with a byte FIFO. It sits between the serial `rxd` pin and the processor core's input instruction: it deserialises 8N1 frames from the host-side transmitter and buffers them. The core drains them with a valid/ready pop handshake. Framing errors and overflow are reported through sticky flags that the core can clear.

## Interface
Parameters:
- `CLK_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Minimum 8.
- `DEPTH`, default 16: FIFO entries. Power of two, minimum 2.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `rxd`  in  1: asynchronous serial input. Idle level is high.
- `rdata`  out  8: FIFO head byte. Valid only while `rvalid` = 1.
- `rvalid`  out  1: FIFO not empty.
- `rready`  in  1: core pops the head when `rvalid && rready`.
- `count`  out  $clog2(DEPTH+1): number of bytes held.
- `clr_err`  in  1: clears `overrun` and `ferr`.
- `overrun`  out  1: sticky; a received byte was dropped because the FIFO was full.
- `ferr`  out  1: sticky; a stop bit was sampled low.

## Operation
- **Input synchroniser:** two-flop synchroniser on `rxd`, giving `rxd_s`. Both flops reset to 1. One further register `rxd_d` holds the previous `rxd_s` for edge detection.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH. A bit counter and a baud counter (width $clog2(CLK_PER_BIT)) run inside the FSM.
- **IDLE:** when `rxd_d` = 1 and `rxd_s` = 0, go to START and clear the baud counter.
- **START:** at baud count `CLK_PER_BIT/2 - 1`, sample `rxd_s`.
  - Sample 0: go to DATA with bit index 0.
  - Sample 1: treat as a glitch and return to IDLE.
- **DATA:** every `CLK_PER_BIT` cycles, sample one bit into the shift register, LSB first. After bit 7, go to STOP.
- **STOP:** after `CLK_PER_BIT` cycles, sample `rxd_s`.
  - Sample 1: push the assembled byte, go to IDLE.
  - Sample 0: set `ferr`, push nothing, go to WAIT_HIGH.
- **WAIT_HIGH:** go to IDLE on the first cycle with `rxd_s` = 1. This prevents a break condition from being read as a stream of 0x00 frames.
- **FIFO:** first-word-fall-through. `rdata` is the head entry, driven combinationally from the storage array. Read and write pointers are `$clog2(DEPTH)` bits and wrap naturally.
- **Push while full:**
  - If no pop occurs in the same cycle, drop the byte and set `overrun`.
  - If a pop occurs in the same cycle, accept the push; `count` is unchanged.
- **Pop when empty** (`rready` = 1, `rvalid` = 0): no effect.
- **Error flags:** when `clr_err` and a new error event coincide, the flag ends up set (set wins). Neither flag affects data flow.
- **Reset values:** `rvalid` 0, `count` 0, `overrun` 0, `ferr` 0, FSM in IDLE, both pointers 0. `rdata` is don't-care while `rvalid` = 0.
- **Reset mid-frame:** the partial byte is discarded and the FIFO is emptied. Reception resumes at the next falling edge seen after reset deasserts.

## Timing
- Let T be the first cycle the FSM is in START. `rxd_s` lags the pin by 2 cycles.
- Sample points:
  - Start bit: T + CLK_PER_BIT/2 − 1.
  - Data bit i: T + CLK_PER_BIT/2 − 1 + (i+1)·CLK_PER_BIT.
  - Stop bit: T + CLK_PER_BIT/2 − 1 + 9·CLK_PER_BIT.
- `rvalid` and `count` update on the cycle after the stop sample.
- A pop takes effect at the clock edge where `rvalid && rready` holds. The new head appears on `rdata` in the following cycle.
- Back-to-back frames with zero idle time are supported. The FSM is in IDLE by mid-stop-bit, ahead of the next start edge.
- Sustained throughput is one byte per 10·CLK_PER_BIT cycles. The FIFO never back-pressures the line.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding localparams (IDLE = 0 … WAIT_HIGH = 4);
  - `UART_CLK_PER_BIT_DEFAULT` = 868.
  The TX side imports the same package.
- Sub-module `sync_fifo #(WIDTH, DEPTH)` contains the storage, pointers, `count`, and the full/empty logic. It exposes `push`, `pop` and a `full` output; overrun detection is done in the parent.
- The receiver FSM, synchroniser and error flags live in `uart_rx_fifo`.

## Test plan
All scenarios use `CLK_PER_BIT` = 16 and `DEPTH` = 4, driving `rxd` with a bit-accurate serial model.
1. Send 0x55 with `rready` = 0 → `rvalid` rises at T + 8 − 1 + 144 + 1 = T + 152 with `rdata` = 0x55 and `count` = 1. Pulse `rready` → `rvalid` = 0, `count` = 0.
2. Send 0x00, 0x01, 0x02, 0x03, 0xA5 back-to-back with no pops → `count` = 4 and `overrun` = 1. Popping yields 0x00..0x03 in order; 0xA5 is absent. `clr_err` → `overrun` = 0.
3. Send 0x3C with the stop bit held low, then release the line high and send 0x81 → `ferr` = 1, no push for 0x3C, then 0x81 is received with `count` = 1.
4. Drive a 4-cycle low glitch on `rxd` → FSM returns to IDLE, `count` remains 0, `ferr` remains 0.
5. With the FIFO full (0x10..0x13), hold `rready` = 1 so a pop coincides with the push of 0x14 → `count` stays 4, `overrun` = 0, and the drained order is 0x11, 0x12, 0x13, 0x14.
6. Assert `rst` for one cycle during bit 3 of a frame while `count` = 2 → `count` = 0 and `rvalid` = 0. The next frame, 0xC3, is received correctly.
